// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampling, 2-flop synchroniser, majority-vote sampling,
// configurable parity/stop checking and a first-word fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    input  logic                 UART_RX,
    input  logic                 enable,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 busy
);
    localparam int unsigned Div  = CLK_HZ / (BAUD * 16);
    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                 state_q, state_d;
    logic                   sync1_q, rx_s_q, rx_prev_q;
    logic [CntW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [3:0]             samp_q, samp_d;
    logic [1:0]             ones_q, ones_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_fail_q, par_fail_d, stop_bad_q, stop_bad_d;
    logic                   tick, maj, sample_tick, vote_tick, end_tick;
    logic                   done, done_ferr, done_perr;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]            wp_q, rp_q;
    logic                   full, empty, push, pop;

    assign tick        = (tick_cnt_q == CntW'(Div - 1));
    assign sample_tick = tick && (samp_q == 4'd7 || samp_q == 4'd8);
    assign vote_tick   = tick && (samp_q == 4'd9);
    assign end_tick    = tick && (samp_q == 4'd15);
    // Majority of the two stored samples (ticks 7, 8) and the live one at tick 9.
    assign maj         = (ones_q == 2'd2) || (ones_q == 2'd1 && rx_s_q);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            tick_cnt_q <= '0;
            samp_q     <= '0;
            ones_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_fail_q <= 1'b0;
            stop_bad_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= UART_RX;
            rx_s_q     <= sync1_q;
            rx_prev_q  <= rx_s_q;
            tick_cnt_q <= tick_cnt_d;
            samp_q     <= samp_d;
            ones_q     <= ones_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_fail_q <= par_fail_d;
            stop_bad_q <= stop_bad_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        samp_d     = tick ? samp_q + 4'd1 : samp_q;
        ones_d     = (sample_tick && rx_s_q) ? ones_q + 2'd1 : ones_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_fail_d = par_fail_q;
        stop_bad_d = stop_bad_q;
        if (end_tick) begin
            ones_d = '0;
        end
        unique case (state_q)
            StIdle: begin
                if (enable && rx_prev_q && !rx_s_q) begin
                    state_d    = StStart;
                    tick_cnt_d = '0;
                    samp_d     = '0;
                    ones_d     = '0;
                    bit_d      = '0;
                    par_fail_d = 1'b0;
                    stop_bad_d = 1'b0;
                end
            end
            StStart: begin
                if (vote_tick && maj) begin
                    state_d = StIdle;
                end else if (end_tick) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (vote_tick) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                end
                if (end_tick) begin
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (vote_tick && ((^shift_q ^ maj) != (PARITY == 2))) begin
                    par_fail_d = 1'b1;
                end
                if (end_tick) begin
                    state_d = StStop;
                    bit_d   = '0;
                end
            end
            StStop: begin
                if (vote_tick) begin
                    if (!maj) begin
                        stop_bad_d = 1'b1;
                    end
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        state_d = StIdle;
                    end
                end
                if (end_tick) begin
                    bit_d = bit_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!enable) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        busy      = (state_q != StIdle);
        done      = enable && (state_q == StStop) && vote_tick && (bit_q == 3'(STOP_BITS - 1));
        done_ferr = stop_bad_q || !maj;
        done_perr = par_fail_q;
    end

    assign empty      = (wp_q == rp_q);
    assign full       = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign pop        = !empty && data_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push       = done && (!full || pop);
    assign data       = mem_q[rp_q[AW-1:0]];
    assign data_valid = !empty;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wp_q       <= '0;
            rp_q       <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wp_q[AW-1:0]] <= shift_q;
                wp_q                <= wp_q + 1'b1;
            end
            if (pop) begin
                rp_q <= rp_q + 1'b1;
            end
            if (done && done_ferr) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (done && done_perr) begin
                parity_err <= 1'b1;
            end else if (err_clr) begin
                parity_err <= 1'b0;
            end
            if (done && !push) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and an 8E2 instance share one serial line,
// selected via their enables; a small oversampling divider keeps frames short.
module tb_uart_rx_fifo;
    localparam int unsigned ClkHz  = 614400;
    localparam int unsigned Baud   = 9600;
    localparam int          BitCyc = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, rx, en_n, en_p, rdy_n, rdy_p, err_clr;
    logic [7:0] data_n, data_p;
    logic       dv_n, dv_p, fe_n, fe_p, pe_n, pe_p, ov_n, ov_p, busy_n, busy_p;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] got_n[$];
    logic [7:0] got_p[$];
    logic [7:0] exp_q[$];
    logic       exp_fe;

    typedef struct {
        logic [7:0] b;
        bit         stop_low;
        bit         clr_after;
        logic       exp_fe;
    } vec_t;
    vec_t vecs[7];

    uart_rx_fifo #(.CLK_HZ(ClkHz), .BAUD(Baud), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                   .FIFO_DEPTH(4)) dut_n (
        .sysclk(clk), .reset_n(reset_n), .UART_RX(rx), .enable(en_n), .data(data_n),
        .data_valid(dv_n), .data_ready(rdy_n), .frame_err(fe_n), .parity_err(pe_n),
        .overrun(ov_n), .err_clr(err_clr), .busy(busy_n));

    uart_rx_fifo #(.CLK_HZ(ClkHz), .BAUD(Baud), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2),
                   .FIFO_DEPTH(4)) dut_p (
        .sysclk(clk), .reset_n(reset_n), .UART_RX(rx), .enable(en_p), .data(data_p),
        .data_valid(dv_p), .data_ready(rdy_p), .frame_err(fe_p), .parity_err(pe_p),
        .overrun(ov_p), .err_clr(err_clr), .busy(busy_p));

    // Record every byte the consumer actually pops.
    always @(negedge clk) begin
        if (reset_n && dv_n && rdy_n) got_n.push_back(data_n);
        if (reset_n && dv_p && rdy_p) got_p.push_back(data_p);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int par_mode, input bit par_flip,
                              input int nstop, input bit stop_low);
        rx = 1'b0;
        step(BitCyc);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(BitCyc);
        end
        if (par_mode != 0) begin
            rx = (^b) ^ (par_mode == 2) ^ par_flip;
            step(BitCyc);
        end
        for (int s = 0; s < nstop; s++) begin
            rx = ~stop_low;
            step(BitCyc);
        end
        rx = 1'b1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    task automatic check_one(input string name, input logic [7:0] exp);
        chk8({name, "_cnt"}, 8'(got_n.size()), 8'd1);
        if (got_n.size() > 0) chk8({name, "_byte"}, got_n[0], exp);
        got_n.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk8({tag, "_data_n"}, data_n, 8'h00);
        chk1({tag, "_dv_n"}, dv_n, 1'b0);
        chk1({tag, "_fe_n"}, fe_n, 1'b0);
        chk1({tag, "_pe_n"}, pe_n, 1'b0);
        chk1({tag, "_ov_n"}, ov_n, 1'b0);
        chk1({tag, "_busy_n"}, busy_n, 1'b0);
        chk8({tag, "_data_p"}, data_p, 8'h00);
        chk1({tag, "_dv_p"}, dv_p, 1'b0);
    endtask

    initial begin
        vecs[0] = '{8'h12, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h55, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h12, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{8'h01, 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0; rx = 1'b1; en_n = 1'b0; en_p = 1'b0;
        rdy_n = 1'b1; rdy_p = 1'b1; err_clr = 1'b0;
        step(3);
        check_zero_outputs("reset");
        reset_n = 1'b1;
        en_n = 1'b1;
        step(8);

        // Basic 8N1 frame.
        send_frame(8'hA5, 0, 1'b0, 1, 1'b0);
        step(8);
        check_one("a5", 8'hA5);
        chk1("a5_fe", fe_n, 1'b0);
        chk1("a5_ov", ov_n, 1'b0);
        chk1("a5_busy", busy_n, 1'b0);

        // Start-bit glitch, shorter than the 7..9 tick sampling window.
        rx = 1'b0;
        step(10);
        chk1("glitch_busy_hi", busy_n, 1'b1);
        step(8);
        rx = 1'b1;
        step(BitCyc);
        chk1("glitch_busy_lo", busy_n, 1'b0);
        chk8("glitch_cnt", 8'(got_n.size()), 8'd0);
        chk1("glitch_fe", fe_n, 1'b0);

        foreach (vecs[i]) begin
            send_frame(vecs[i].b, 0, 1'b0, 1, vecs[i].stop_low);
            step(vecs[i].stop_low ? 16 : 8);
            check_one($sformatf("tbl%0d", i), vecs[i].b);
            chk1($sformatf("tbl%0d_fe", i), fe_n, vecs[i].exp_fe);
            if (vecs[i].clr_after) begin
                pulse_clr();
                chk1($sformatf("tbl%0d_clr", i), fe_n, 1'b0);
            end
        end

        // Enable dropped mid-frame discards the frame.
        fork
            send_frame(8'h99, 0, 1'b0, 1, 1'b0);
            begin
                step(BitCyc * 3);
                chk1("en_busy_hi", busy_n, 1'b1);
                en_n = 1'b0;
                step(1);
                chk1("en_busy_lo", busy_n, 1'b0);
            end
        join
        step(4);
        en_n = 1'b1;
        step(4);
        chk8("en_cnt", 8'(got_n.size()), 8'd0);
        chk1("en_fe", fe_n, 1'b0);

        // Even parity, two stop bits.
        en_n = 1'b0; en_p = 1'b1;
        step(4);
        send_frame(8'h03, 1, 1'b1, 2, 1'b0);
        step(8);
        chk8("par_cnt", 8'(got_p.size()), 8'd1);
        if (got_p.size() > 0) chk8("par_byte", got_p[0], 8'h03);
        chk1("par_pe", pe_p, 1'b1);
        chk1("par_fe", fe_p, 1'b0);
        pulse_clr();
        chk1("par_clr", pe_p, 1'b0);
        got_p.delete();
        send_frame(8'h5A, 1, 1'b0, 2, 1'b0);
        step(8);
        chk8("par_ok_cnt", 8'(got_p.size()), 8'd1);
        if (got_p.size() > 0) chk8("par_ok_byte", got_p[0], 8'h5A);
        chk1("par_ok_pe", pe_p, 1'b0);
        got_p.delete();
        send_frame(8'hC3, 1, 1'b0, 2, 1'b1);
        step(16);
        chk1("par_stop_fe", fe_p, 1'b1);
        chk1("par_stop_pe", pe_p, 1'b0);
        chk8("par_stop_cnt", 8'(got_p.size()), 8'd1);
        pulse_clr();
        en_p = 1'b0; en_n = 1'b1;
        step(4);

        // Overrun: five back-to-back frames into a four-entry FIFO.
        rdy_n = 1'b0;
        got_n.delete();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 1'b0, 1, 1'b0);
        step(8);
        chk1("ovr_flag", ov_n, 1'b1);
        chk1("ovr_dv", dv_n, 1'b1);
        chk8("ovr_head", data_n, 8'h01);
        rdy_n = 1'b1;
        step(8);
        chk8("ovr_cnt", 8'(got_n.size()), 8'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_n.size()) chk8($sformatf("ovr_pop%0d", i), got_n[i], 8'(i + 1));
        end
        chk1("ovr_empty", dv_n, 1'b0);
        pulse_clr();
        chk1("ovr_clr", ov_n, 1'b0);
        got_n.delete();

        // Reset in the middle of a frame, with state worth clearing.
        rdy_n = 1'b0;
        send_frame(8'h44, 0, 1'b0, 1, 1'b1);
        step(16);
        chk1("pre_rst_dv", dv_n, 1'b1);
        chk1("pre_rst_fe", fe_n, 1'b1);
        fork
            send_frame(8'h7E, 0, 1'b0, 1, 1'b0);
            begin
                step(BitCyc * 4);
                chk1("pre_rst_busy", busy_n, 1'b1);
                reset_n = 1'b0;
                #1;
                check_zero_outputs("midrst");
            end
        join
        step(4);
        reset_n = 1'b1;
        rdy_n = 1'b1;
        step(8);
        send_frame(8'h3C, 0, 1'b0, 1, 1'b0);
        step(8);
        check_one("after_rst", 8'h3C);

        // Randomised frames against a queue model.
        got_n.delete();
        exp_q.delete();
        exp_fe = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            bit         sl;
            b  = 8'($urandom_range(0, 255));
            sl = ($urandom_range(0, 7) == 0);
            send_frame(b, 0, 1'b0, 1, sl);
            exp_q.push_back(b);
            exp_fe = exp_fe | sl;
            step(sl ? 16 : int'($urandom_range(0, 12)));
        end
        step(8);
        chk8("rnd_cnt", 8'(got_n.size()), 8'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_n.size()) chk8($sformatf("rnd%0d", i), got_n[i], exp_q[i]);
        end
        chk1("rnd_fe", fe_n, exp_fe);
        chk1("rnd_pe", pe_n, 1'b0);
        chk1("rnd_ov", ov_n, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
